lsu_stage: RTL and testbench

LSU_STAGE -- requirements
Module: ysyx_22051013_lsu

---
 rtl/lsu_stage.sv | 187 ++++++++++++++++++
 tb/tb_lsu_stage.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_stage.sv
// Load/store stage: takes one instruction from EX, issues at most one aligned
// doubleword memory access, and hands a single result to write-back.
module lsu_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ls_ready,
  input  logic [3:0]  mem_op,
  input  logic [4:0]  rd_addr,
  input  logic [63:0] exu_res,
  input  logic [63:0] store_data,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [63:0] mem_addr,
  output logic        mem_wen,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wstrb,
  input  logic        mem_rsp_valid,
  input  logic [63:0] mem_rdata,
  output logic        ls_valid,
  input  logic        wb_ready,
  output logic [63:0] ls_res,
  output logic [4:0]  ls_rd_addr,
  output logic        ls_misalign
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  // Access size code: 0 byte, 1 half, 2 word, 3 doubleword.
  function automatic logic [1:0] op_size(input logic [3:0] op);
    logic [1:0] s;
    s = 2'd0;
    case (op)
      4'd2, 4'd6, 4'd9:  s = 2'd1;
      4'd3, 4'd7, 4'd10: s = 2'd2;
      4'd4, 4'd11:       s = 2'd3;
      default:           s = 2'd0;
    endcase
    return s;
  endfunction

  function automatic logic op_is_load(input logic [3:0] op);
    return (op != 4'd0) && !op[3];
  endfunction

  function automatic logic op_is_store(input logic [3:0] op);
    return op[3] && !op[2];
  endfunction

  // LB/LH/LW/LD sign-extend; the unsigned loads and everything else do not.
  function automatic logic op_sext(input logic [3:0] op);
    return (op != 4'd0) && (op <= 4'd4);
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] off);
    logic m;
    m = 1'b0;
    case (size)
      2'd1:    m = off[0];
      2'd2:    m = |off[1:0];
      2'd3:    m = |off;
      default: m = 1'b0;
    endcase
    return m;
  endfunction

  state_e      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [4:0]  rd_q, rd_d;
  logic [63:0] exu_q, exu_d;
  logic [63:0] sdata_q, sdata_d;
  logic [63:0] res_q, res_d;
  logic        mis_q, mis_d;

  logic [2:0]  off_q;
  logic [1:0]  size_q;
  logic [63:0] rdata_sh;
  logic [63:0] load_val;
  logic [7:0]  size_mask;
  logic        in_mem;

  assign off_q  = exu_q[2:0];
  assign size_q = op_size(op_q);
  assign in_mem = op_is_load(mem_op) || op_is_store(mem_op);

  // Align the addressed bytes to bit 0 and extend to 64 bits.
  always_comb begin
    rdata_sh = mem_rdata >> {off_q, 3'b000};
    load_val = '0;
    case (size_q)
      2'd0:    load_val = {{56{op_sext(op_q) & rdata_sh[7]}}, rdata_sh[7:0]};
      2'd1:    load_val = {{48{op_sext(op_q) & rdata_sh[15]}}, rdata_sh[15:0]};
      2'd2:    load_val = {{32{op_sext(op_q) & rdata_sh[31]}}, rdata_sh[31:0]};
      default: load_val = rdata_sh;
    endcase
  end

  // Memory request fields, derived from the latched instruction so they stay stable in StReq.
  always_comb begin
    size_mask = 8'h01;
    case (size_q)
      2'd1:    size_mask = 8'h03;
      2'd2:    size_mask = 8'h0F;
      2'd3:    size_mask = 8'hFF;
      default: size_mask = 8'h01;
    endcase
    mem_req_valid = (state_q == StReq);
    mem_addr      = {exu_q[63:3], 3'b000};
    mem_wdata     = sdata_q << {off_q, 3'b000};
    mem_wen       = (state_q == StReq) && op_is_store(op_q);
    mem_wstrb     = mem_wen ? (size_mask << off_q) : 8'h00;
    ls_ready      = (state_q == StIdle);
    ls_valid      = (state_q == StDone);
    ls_res        = res_q;
    ls_rd_addr    = rd_q;
    ls_misalign   = mis_q;
  end

  // Next-state logic: accept, request, wait for response, present result.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rd_d    = rd_q;
    exu_d   = exu_q;
    sdata_d = sdata_q;
    res_d   = res_q;
    mis_d   = mis_q;
    unique case (state_q)
      StIdle: begin
        if (ex_valid) begin
          op_d    = mem_op;
          rd_d    = rd_addr;
          exu_d   = exu_res;
          sdata_d = store_data;
          if (!in_mem) begin
            res_d   = exu_res;
            mis_d   = 1'b0;
            state_d = StDone;
          end else if (is_misaligned(op_size(mem_op), exu_res[2:0])) begin
            res_d   = '0;
            mis_d   = 1'b1;
            state_d = StDone;
          end else begin
            mis_d   = 1'b0;
            state_d = StReq;
          end
        end
      end
      StReq: begin
        if (mem_req_ready) state_d = StWait;
      end
      StWait: begin
        // Stores use the response purely as a write acknowledge.
        if (mem_rsp_valid) begin
          res_d   = op_is_load(op_q) ? load_val : '0;
          state_d = StDone;
        end
      end
      StDone: begin
        if (wb_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and latched-instruction registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= '0;
      rd_q    <= '0;
      exu_q   <= '0;
      sdata_q <= '0;
      res_q   <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      exu_q   <= exu_d;
      sdata_q <= sdata_d;
      res_q   <= res_d;
      mis_q   <= mis_d;
    end
  end

endmodule

// File: tb/tb_lsu_stage.sv
// Scoreboard bench for lsu_stage: expected results are queued at accept time
// and compared when the stage presents them to write-back.
module tb_lsu_stage;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic        ls_ready;
  logic [3:0]  mem_op;
  logic [4:0]  rd_addr;
  logic [63:0] exu_res;
  logic [63:0] store_data;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_addr;
  logic        mem_wen;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wstrb;
  logic        mem_rsp_valid;
  logic [63:0] mem_rdata;
  logic        ls_valid;
  logic        wb_ready;
  logic [63:0] ls_res;
  logic [4:0]  ls_rd_addr;
  logic        ls_misalign;

  lsu_stage dut (
    .clk           (clk),
    .rst           (rst),
    .ex_valid      (ex_valid),
    .ls_ready      (ls_ready),
    .mem_op        (mem_op),
    .rd_addr       (rd_addr),
    .exu_res       (exu_res),
    .store_data    (store_data),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr),
    .mem_wen       (mem_wen),
    .mem_wdata     (mem_wdata),
    .mem_wstrb     (mem_wstrb),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rdata     (mem_rdata),
    .ls_valid      (ls_valid),
    .wb_ready      (wb_ready),
    .ls_res        (ls_res),
    .ls_rd_addr    (ls_rd_addr),
    .ls_misalign   (ls_misalign)
  );

  typedef struct {
    logic [63:0] res;
    logic [4:0]  rd;
    logic        mis;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int m_size(input logic [3:0] op);
    case (op)
      4'd1, 4'd5, 4'd8:  return 1;
      4'd2, 4'd6, 4'd9:  return 2;
      4'd3, 4'd7, 4'd10: return 4;
      4'd4, 4'd11:       return 8;
      default:           return 0;
    endcase
  endfunction

  function automatic logic m_is_ld(input logic [3:0] op);
    return op inside {[4'd1:4'd7]};
  endfunction

  function automatic logic m_is_st(input logic [3:0] op);
    return op inside {[4'd8:4'd11]};
  endfunction

  function automatic logic m_mis(input logic [3:0] op, input logic [63:0] a);
    int sz;
    sz = m_size(op);
    return (sz > 1) && ((int'(a[2:0]) % sz) != 0);
  endfunction

  function automatic logic [63:0] m_load(input logic [3:0] op, input logic [63:0] a,
                                         input logic [63:0] rdata);
    int          sz;
    logic        sx;
    logic [63:0] v;
    logic [63:0] r;
    sz = m_size(op);
    sx = op inside {[4'd1:4'd4]};
    v  = rdata >> (8 * int'(a[2:0]));
    for (int i = 0; i < 64; i++) r[i] = (i < 8 * sz) ? v[i] : (sx ? v[8 * sz - 1] : 1'b0);
    return r;
  endfunction

  task automatic check_req(input logic [3:0] op, input logic [63:0] a, input logic [63:0] sd);
    int          off;
    int          sz;
    logic [7:0]  strb;
    logic [63:0] wd;
    off = int'(a[2:0]);
    sz  = m_size(op);
    wd  = '0;
    for (int i = 0; i < 8; i++) begin
      strb[i] = m_is_st(op) && (i >= off) && (i < off + sz);
      if (i >= off) wd[8 * i +: 8] = sd[8 * (i - off) +: 8];
    end
    check_eq("req_valid", mem_req_valid, 1'b1);
    check_eq("req_addr", mem_addr, {a[63:3], 3'b000});
    check_eq("req_wen", mem_wen, m_is_st(op));
    check_eq("req_wstrb", mem_wstrb, strb);
    if (m_is_st(op)) check_eq("req_wdata", mem_wdata, wd);
  endtask

  // One instruction from accept through write-back, with optional stalls.
  task automatic run_txn(input logic [3:0] op, input logic [63:0] a, input logic [63:0] sd,
                         input logic [4:0] rd, input logic [63:0] rdata,
                         input int req_wait, input int rsp_wait, input int wb_wait);
    exp_t e;
    logic mem;
    mem   = m_is_ld(op) || m_is_st(op);
    e.rd  = rd;
    e.mis = mem && m_mis(op, a);
    if (!mem)       e.res = a;
    else if (e.mis) e.res = '0;
    else if (m_is_st(op)) e.res = '0;
    else            e.res = m_load(op, a, rdata);
    sb.push_back(e);

    ex_valid = 1'b1; mem_op = op; exu_res = a; store_data = sd; rd_addr = rd;
    @(negedge clk);
    check_eq("accept_ready", ls_ready, 1'b1);
    @(posedge clk); #1;
    ex_valid = 1'b0; mem_op = 4'($urandom); exu_res = {$urandom, $urandom};
    store_data = {$urandom, $urandom}; rd_addr = 5'($urandom);

    if (mem && !e.mis) begin
      mem_req_ready = 1'b0;
      for (int i = 0; i < req_wait; i++) begin
        @(negedge clk);
        check_req(op, a, sd);
        @(posedge clk); #1;
      end
      mem_req_ready = 1'b1;
      @(negedge clk);
      check_req(op, a, sd);
      @(posedge clk); #1;
      mem_req_ready = 1'b0;
      for (int i = 0; i < rsp_wait; i++) begin
        @(negedge clk);
        check_eq("wait_noreq", mem_req_valid, 1'b0);
        check_eq("wait_novalid", ls_valid, 1'b0);
        @(posedge clk); #1;
      end
      mem_rdata = rdata; mem_rsp_valid = 1'b1;
      @(negedge clk);
      check_eq("rsp_novalid", ls_valid, 1'b0);
      @(posedge clk); #1;
      mem_rsp_valid = 1'b0; mem_rdata = {$urandom, $urandom};
    end

    @(negedge clk);
    check_eq("done_valid", ls_valid, 1'b1);
    if (!mem || e.mis) check_eq("done_noreq", mem_req_valid, 1'b0);
    for (int i = 0; i < wb_wait; i++) begin
      check_eq("hold_res", ls_res, e.res);
      check_eq("hold_notready", ls_ready, 1'b0);
      @(posedge clk); #1;
      @(negedge clk);
      check_eq("hold_valid", ls_valid, 1'b1);
    end
    e = sb.pop_front();
    check_eq("ls_res", ls_res, e.res);
    check_eq("ls_rd_addr", ls_rd_addr, e.rd);
    check_eq("ls_misalign", ls_misalign, e.mis);
    wb_ready = 1'b1;
    @(posedge clk); #1;
    wb_ready = 1'b0;
    @(negedge clk);
    check_eq("idle_novalid", ls_valid, 1'b0);
    check_eq("idle_ready", ls_ready, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ls_ready"}, ls_ready, 1'b1);
    check_eq({tag, "_ls_valid"}, ls_valid, 1'b0);
    check_eq({tag, "_req_valid"}, mem_req_valid, 1'b0);
    check_eq({tag, "_wen"}, mem_wen, 1'b0);
    check_eq({tag, "_wstrb"}, mem_wstrb, 8'h00);
    check_eq({tag, "_misalign"}, ls_misalign, 1'b0);
    check_eq({tag, "_addr"}, mem_addr, 64'h0);
    check_eq({tag, "_wdata"}, mem_wdata, 64'h0);
    check_eq({tag, "_ls_res"}, ls_res, 64'h0);
    check_eq({tag, "_rd"}, ls_rd_addr, 5'h0);
  endtask

  initial begin
    rst = 1'b1; ex_valid = 1'b0; mem_op = '0; rd_addr = '0; exu_res = '0; store_data = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0; wb_ready = 1'b0;
    #2;
    check_reset_outputs("por");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run_txn(4'b0000, 64'h1234, 64'h0, 5'd5, 64'h0, 0, 0, 0);
    check_eq("pt_value", ls_res, 64'h1234);
    run_txn(4'b0001, 64'h8000_0003, 64'h0, 5'd7, 64'h0000_0000_8000_0000, 0, 0, 0);
    check_eq("lb_value", ls_res, 64'hFFFF_FFFF_FFFF_FF80);
    run_txn(4'b1001, 64'h1006, 64'hABCD, 5'd9, 64'h0, 0, 0, 0);
    run_txn(4'b0011, 64'h1002, 64'h0, 5'd3, 64'h0, 0, 0, 0);
    run_txn(4'b1011, 64'h2000, 64'h0123_4567_89AB_CDEF, 5'd11, 64'h0, 4, 0, 3);
    run_txn(4'b0100, 64'h3000, 64'h0, 5'd12, 64'hFEDC_BA98_7654_3210, 1, 2, 1);
    run_txn(4'b0101, 64'h3007, 64'h0, 5'd13, 64'hF100_0000_0000_0000, 0, 0, 0);
    run_txn(4'b0110, 64'h3002, 64'h0, 5'd14, 64'h0000_0000_9876_0000, 0, 1, 0);
    run_txn(4'b0111, 64'h3004, 64'h0, 5'd15, 64'h8765_4321_0000_0000, 2, 0, 0);
    run_txn(4'b0010, 64'h3006, 64'h0, 5'd16, 64'h8001_0000_0000_0000, 0, 0, 2);
    run_txn(4'b1000, 64'h4005, 64'h77, 5'd17, 64'h0, 0, 0, 0);
    run_txn(4'b1010, 64'h4004, 64'hDEAD_BEEF, 5'd18, 64'h0, 0, 0, 0);
    run_txn(4'b1011, 64'h4004, 64'h1, 5'd19, 64'h0, 0, 0, 0);
    run_txn(4'b1100, 64'hCAFE_0001, 64'h0, 5'd20, 64'h0, 0, 0, 0);

    for (int t = 0; t < 24; t++)
      run_txn(4'($urandom_range(0, 15)), {$urandom, $urandom}, {$urandom, $urandom},
              5'($urandom), {$urandom, $urandom}, $urandom_range(0, 2),
              $urandom_range(0, 2), $urandom_range(0, 2));

    // Response outside StWait must not produce a result.
    mem_rsp_valid = 1'b1;
    @(negedge clk);
    check_eq("stray_rsp_idle", ls_valid, 1'b0);
    @(posedge clk); #1;
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    check_eq("stray_rsp_after", ls_valid, 1'b0);
    @(posedge clk); #1;

    // Reset while waiting for a load response abandons the access.
    ex_valid = 1'b1; mem_op = 4'b0011; exu_res = 64'h5008; rd_addr = 5'd21;
    store_data = 64'h55;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    mem_req_ready = 1'b1;
    @(negedge clk);
    check_eq("rst_req_valid", mem_req_valid, 1'b1);
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    @(negedge clk);
    check_eq("rst_wait_noreq", mem_req_valid, 1'b0);
    #1;
    rst = 1'b1;
    #1;
    check_reset_outputs("midwait");
    @(posedge clk); #1;
    rst = 1'b0;
    mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    mem_rsp_valid = 1'b1;
    @(negedge clk);
    check_eq("stale_rsp_valid", ls_valid, 1'b0);
    @(posedge clk); #1;
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    check_eq("stale_rsp_valid2", ls_valid, 1'b0);
    check_eq("stale_rsp_ready", ls_ready, 1'b1);
    check_eq("stale_rsp_res", ls_res, 64'h0);
    @(posedge clk); #1;

    run_txn(4'b0000, 64'h9999, 64'h0, 5'd22, 64'h0, 0, 0, 0);
    check_eq("sb_empty", 64'(sb.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
